// File: rtl/if_prefetch_if.sv
// Fetch-unit boundary: UPG program-load port, run control, redirect and the decode-side
// valid/ready instruction stream.
interface if_prefetch_if;
    logic        upg_rst_i;
    logic        upg_wen_i;
    logic [14:0] upg_adr_i;
    logic [31:0] upg_dat_i;
    logic        upg_done_i;
    logic        inited;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_ready_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [1:0]  state_o;

    modport master (
        output upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i, inited,
               redirect_i, redirect_pc_i, inst_ready_i,
        input  inst_valid_o, inst_o, inst_pc_o, state_o
    );

    modport slave (
        input  upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i, inited,
               redirect_i, redirect_pc_i, inst_ready_i,
        output inst_valid_o, inst_o, inst_pc_o, state_o
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction fetch: UPG-loadable ROM, fetch PC and DEPTH-entry {pc, inst} prefetch FIFO.
// Latency issue->valid 2 cycles; issue only while registered count + inflight < DEPTH.
module if_prefetch #(
    parameter int          ADDR_W   = 14,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    if_prefetch_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    typedef enum logic [1:0] {
        S_LOAD = 2'b00,
        S_WAIT = 2'b01,
        S_RUN  = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     tag_q;
    logic            inflight_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [31:0]     rom_dat_q;
    logic [31:0]     mem        [2**ADDR_W];
    logic [31:0]     fifo_inst_q[DEPTH];
    logic [31:0]     fifo_pc_q  [DEPTH];

    logic            kick_off, flush_mode, redir, flush, issue, push, pop;
    logic [CW:0]     occupancy;

    assign kick_off = bus.upg_rst_i | bus.upg_done_i;

    always_comb begin
        state_d = state_q;
        if (!kick_off)                               state_d = S_LOAD;
        else if (state_q == S_LOAD)                  state_d = S_WAIT;
        else if (state_q == S_WAIT && bus.inited)    state_d = S_RUN;
        else if (state_q == S_RUN && !bus.inited)    state_d = S_WAIT;
    end

    // Mode changes beat redirect; either one discards FIFO contents and the inflight read.
    assign flush_mode = (state_d == S_LOAD) || (state_q == S_RUN && state_d != S_RUN);
    assign redir      = (state_q == S_RUN) && bus.redirect_i && !flush_mode;
    assign flush      = flush_mode | redir;
    assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue      = (state_q == S_RUN) && (state_d == S_RUN) && !redir && (occupancy < DEPTH_C);
    assign push       = inflight_q && !flush;
    assign pop        = (count_q != '0) && bus.inst_ready_i && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_LOAD;
            fetch_pc_q <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                inflight_q <= 1'b0;
                count_q    <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                fetch_pc_q <= flush_mode ? RESET_PC : {bus.redirect_pc_i[31:2], 2'b00};
            end else begin
                inflight_q <= issue;
                if (issue) begin
                    tag_q      <= fetch_pc_q;
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && bus.upg_wen_i && !bus.upg_adr_i[14])
            mem[bus.upg_adr_i[ADDR_W-1:0]] <= bus.upg_dat_i;
        if (issue)
            rom_dat_q <= mem[fetch_pc_q[ADDR_W+1:2]];
    end

    // Payload needs no reset: outputs are masked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= rom_dat_q;
            fifo_pc_q[wr_ptr_q]   <= tag_q;
        end
    end

    assign bus.inst_valid_o = (count_q != '0);
    assign bus.inst_o       = bus.inst_valid_o ? fifo_inst_q[rd_ptr_q] : 32'h0;
    assign bus.inst_pc_o    = bus.inst_valid_o ? fifo_pc_q[rd_ptr_q]   : 32'h0;
    assign bus.state_o      = state_q;
endmodule
